// File: rtl/mixer_ctrl_if.sv
// Command and mixer-side signal bundle for mixer_ctrl.
// master drives commands and mixer status; slave is the controller.
interface mixer_ctrl_if #(
    parameter int data_width = 16
);
    logic                  cmd_valid;
    logic [1:0]            cmd_op;
    logic [data_width-1:0] cmd_data;
    logic                  cmd_ready;
    logic                  frame_tick;
    logic                  pipelines_swapping;
    logic [data_width-1:0] data_out;
    logic                  set_input_gain;
    logic                  set_output_gain;
    logic                  swap_pipelines;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data, frame_tick, pipelines_swapping,
        input  cmd_ready, data_out, set_input_gain, set_output_gain,
               swap_pipelines, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, frame_tick, pipelines_swapping,
        output cmd_ready, data_out, set_input_gain, set_output_gain,
               swap_pipelines, busy
    );
endinterface

// File: rtl/mixer_ctrl.sv
// Frame-synchronous mixer command sequencer: queues gain/swap commands and
// issues one per frame tick. Define MIXER_CTRL_RAMP_EN for output-gain ramping.
//
// state | meaning
// IDLE  | waiting for frame_tick; pops one issuable head entry on a tick
// ISSUE | one-cycle strobe for the popped command
// RAMP  | one-cycle set_output_gain pulse carrying the new ramped gain
module mixer_ctrl #(
    parameter int                    data_width = 16,
    parameter int                    gain_shift = 4,
    parameter int                    depth_log2 = 2,
    parameter logic [data_width-1:0] ramp_step  = 'h0010
) (
    input  logic        clk,
    input  logic        reset,
    mixer_ctrl_if.slave bus
);

    localparam int depth = 1 << depth_log2;
    localparam logic [depth_log2:0] depth_cnt = (depth_log2 + 1)'(depth);

    localparam logic [1:0] op_nop  = 2'd0;
    localparam logic [1:0] op_in   = 2'd1;
    localparam logic [1:0] op_out  = 2'd2;
    localparam logic [1:0] op_swap = 2'd3;

    if (gain_shift < 0 || gain_shift > data_width - 2 || depth_log2 < 1 ||
        ramp_step == '0) begin : g_cfg_check
        $error("mixer_ctrl: unsupported parameter set");
    end

`ifdef MIXER_CTRL_RAMP_EN
    localparam logic [data_width-1:0] unity = data_width'(1) << (data_width - 1 - gain_shift);
    typedef enum logic [1:0] {IDLE, ISSUE, RAMP} state_t;
`else
    typedef enum logic [0:0] {IDLE, ISSUE} state_t;
`endif

    state_t state_q, state_d;

    logic [data_width-1:0] fifo_data [depth];
    logic [1:0]            fifo_op   [depth];
    logic [depth_log2-1:0] wr_ptr, rd_ptr;
    logic [depth_log2:0]   count;

    logic [1:0]            op_q;
    logic [data_width-1:0] data_q;

    logic                  full, empty, push, pop, issuable;
    logic [1:0]            head_op;
    logic [data_width-1:0] head_data;

`ifdef MIXER_CTRL_RAMP_EN
    logic [data_width-1:0] cur_q, target_q, next_cur;
    logic                  step_go;
`endif

    assign full      = (count == depth_cnt);
    assign empty     = (count == '0);
    assign push      = bus.cmd_valid && !full;
    assign head_op   = fifo_op[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    // A swap must not start while the mixer is still crossfading; it blocks the queue.
    assign issuable  = !empty && !(head_op == op_swap && bus.pipelines_swapping);

`ifdef MIXER_CTRL_RAMP_EN
    always_comb begin
        next_cur = cur_q;
        if (target_q > cur_q)
            next_cur = (target_q - cur_q > ramp_step) ? cur_q + ramp_step : target_q;
        else if (target_q < cur_q)
            next_cur = (cur_q - target_q > ramp_step) ? cur_q - ramp_step : target_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
`ifdef MIXER_CTRL_RAMP_EN
        step_go = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.frame_tick) begin
                    if (issuable) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end
`ifdef MIXER_CTRL_RAMP_EN
                    else if (cur_q != target_q) begin
                        step_go = 1'b1;
                        state_d = RAMP;
                    end
`endif
                end
            end
            ISSUE: begin
                state_d = IDLE;
`ifdef MIXER_CTRL_RAMP_EN
                // The tick that popped this entry also owes a ramp step.
                if (cur_q != target_q) begin
                    step_go = 1'b1;
                    state_d = RAMP;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.cmd_data;
            fifo_op[wr_ptr]   <= bus.cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            op_q     <= op_nop;
            data_q   <= '0;
`ifdef MIXER_CTRL_RAMP_EN
            cur_q    <= unity;
            target_q <= unity;
`endif
        end else begin
            state_q <= state_d;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                op_q   <= head_op;
                data_q <= head_data;
`ifdef MIXER_CTRL_RAMP_EN
                if (head_op == op_out)
                    target_q <= head_data;
`endif
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
`ifdef MIXER_CTRL_RAMP_EN
            if (step_go) begin
                cur_q  <= next_cur;
                data_q <= next_cur;
            end
`endif
        end
    end

    // Strobes are gated by reset so a pulse already staged in ISSUE/RAMP is aborted.
    always_comb begin
        bus.set_input_gain  = 1'b0;
        bus.set_output_gain = 1'b0;
        bus.swap_pipelines  = 1'b0;
        if (!reset && state_q == ISSUE) begin
            bus.set_input_gain = (op_q == op_in);
            bus.swap_pipelines = (op_q == op_swap);
`ifndef MIXER_CTRL_RAMP_EN
            bus.set_output_gain = (op_q == op_out);
`endif
        end
`ifdef MIXER_CTRL_RAMP_EN
        if (!reset && state_q == RAMP)
            bus.set_output_gain = 1'b1;
`endif
    end

    assign bus.data_out  = data_q;
    assign bus.cmd_ready = !full;
`ifdef MIXER_CTRL_RAMP_EN
    assign bus.busy = !empty || (state_q != IDLE) || (cur_q != target_q);
`else
    assign bus.busy = !empty || (state_q != IDLE);
`endif

endmodule
